// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into short/long one-cycle pulses, with
// optional auto-repeat while long-held (enabled by defining AUTO_REPEAT_EN).
module button_event_decoder #(
  parameter int LONG_CYCLES   = 100,
  parameter int REPEAT_CYCLES = 20,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Bad parameter sets are rejected at elaboration rather than silently wrapping.
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("button_event_decoder: LONG_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("button_event_decoder: REPEAT_CYCLES must be >= 1");
  end
  if ((LONG_CYCLES - 1 > CNT_MAX) || (REPEAT_CYCLES - 1 > CNT_MAX)) begin : g_bad_width
    $error("button_event_decoder: CNT_W too small for LONG_CYCLES/REPEAT_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             btn_q;
  logic             rise;
  logic             short_next, long_next, repeat_next, held_next;

  assign rise = btn_level & ~btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      // Starting "high" means a button already down at reset release is ignored.
      btn_q       <= 1'b1;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      btn_q       <= btn_level;
      short_pulse <= short_next;
      long_pulse  <= long_next;
      held        <= held_next;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= repeat_next;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    short_next  = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next = PRESSED;
          cnt_next   = CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          short_next = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == LONG_LAST) begin
          long_next  = 1'b1;
          state_next = LONG_HELD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      LONG_HELD: begin
        if (!btn_level) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
`ifdef AUTO_REPEAT_EN
          // cnt restarts at 0 on the long pulse, so the first repeat lands
          // REPEAT_CYCLES samples after it.
          if (cnt_reg == REPEAT_LAST) begin
            repeat_next = 1'b1;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
`endif
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    held_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder (LONG_CYCLES=10, REPEAT_CYCLES=4, CNT_W=4).
`timescale 1ms/100us
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_level = 1'b0;
  logic short_pulse, long_pulse, repeat_pulse, held;
  logic [3:0] outs;

  int total = 0;
  int bad = 0;

  // Expected output vectors, packed as {short, long, repeat, held}.
  localparam logic [3:0] N = 4'b0000;
  localparam logic [3:0] H = 4'b0001;
  localparam logic [3:0] S = 4'b1000;
  localparam logic [3:0] L = 4'b0101;
`ifdef AUTO_REPEAT_EN
  localparam logic [3:0] R = 4'b0011;
`else
  localparam logic [3:0] R = 4'b0001;
`endif

  button_event_decoder #(
    .LONG_CYCLES  (10),
    .REPEAT_CYCLES(4),
    .CNT_W        (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_level   (btn_level),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .held        (held)
  );

  always #5 clk = ~clk;

  assign outs = {short_pulse, long_pulse, repeat_pulse, held};

  task automatic chk(input logic [3:0] exp, input string tag);
    total++;
    assert (outs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, outs, exp);
    end
  endtask

  task automatic step(input logic lvl, input logic [3:0] exp, input string tag);
    btn_level = lvl;
    @(posedge clk);
    #1;
    chk(exp, tag);
    $display("step %-10s btn=%b outs=%b exp=%b", tag, lvl, outs, exp);
  endtask

  initial begin
    // Reset and settle btn_q low
    rst = 1'b1;
    btn_level = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(N, "reset");
    rst = 1'b0;
    step(0, N, "idle");

    // 1: three-sample press -> short
    for (int i = 1; i <= 3; i++) step(1, H, "t1_press");
    step(0, S, "t1_short");
    step(0, N, "t1_after");

    // 2a: nine samples -> still short
    for (int i = 1; i <= 9; i++) step(1, H, "t2a_press");
    step(0, S, "t2a_short");
    step(0, N, "t2a_after");

    // 2b: exactly ten samples -> long, no short on release
    for (int i = 1; i <= 9; i++) step(1, H, "t2b_press");
    step(1, L, "t2b_long");
    step(0, N, "t2b_rel");
    step(0, N, "t2b_after");

    // 3: 22 samples -> long after 10, repeats after 14, 18, 22 when enabled
    for (int i = 1; i <= 22; i++) begin
      if (i == 10)                      step(1, L, "t3_long");
      else if (i > 10 && (i % 4) == 2)  step(1, R, "t3_repeat");
      else                              step(1, H, "t3_held");
    end
    step(0, N, "t3_rel");
    step(0, N, "t3_after");

    // 4: button held across reset release is ignored until re-pressed
    btn_level = 1'b1;
    rst = 1'b1;
    #1;
    chk(N, "t4_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) step(1, N, "t4_ignored");
    step(0, N, "t4_low");
    step(1, H, "t4_press");
    step(1, H, "t4_press");
    step(0, S, "t4_short");
    step(0, N, "t4_after");

    // 5: reset mid-press clears outputs immediately
    for (int i = 1; i <= 6; i++) step(1, H, "t5_press");
    rst = 1'b1;
    #1;
    chk(N, "t5_rst_async");
    #2;
    rst = 1'b0;
    step(0, N, "t5_rel");
    for (int i = 1; i <= 3; i++) step(1, H, "t5_press2");
    step(0, S, "t5_short");
    step(0, N, "t5_after");

    // 6: back-to-back short presses, pulses 3 cycles apart
    step(1, H, "t6_a");
    step(1, H, "t6_a");
    step(0, S, "t6_short1");
    step(1, H, "t6_b");
    step(1, H, "t6_b");
    step(0, S, "t6_short2");
    step(0, N, "t6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
